aes256_key_sched: RTL and testbench

Sequential AES-256 key-schedule engine. It accepts a 256-bit cipher key and streams the 15 round keys (0..14) one per handshake beat, in FIPS-197 order. It sits directly upstream of the iterative AES-256 round datapath and replaces the flat 1920-bit combinational expansion with an 8-word sliding window. The consumer pulls round key n while it executes round n.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes256_key_sched_if.sv | 31 +++
 rtl/aes_sub_word.sv | 17 +
 rtl/aes256_key_sched.sv | 114 +++++++++++
 tb/tb_aes256_key_sched.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-256 key-schedule definitions: word/round counts, the round
// constant table, the forward S-box and the two-state schedule FSM encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NK_256 = 8;
    localparam int NR_256 = 14;

    // Entry 0 is never selected; the schedule indexes it with n/2 for even n >= 2.
    localparam logic [7:0] RCON [8] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } ks_state_e;

endpackage

// File: rtl/aes256_key_sched_if.sv
// ---------------------------------------------------------------------------
// aes256_key_sched_if
// Key-load and round-key handshake bundle of the AES-256 key schedule.
//   key_in/key_valid/key_ready : cipher key in (word 0 = key_in[255:224])
//   rk/rk_idx/rk_last          : current round key, its index, last flag
//   rk_valid/rk_ready          : round-key handshake to the round datapath
// slave  : the key-schedule engine
// master : the side that supplies keys and consumes round keys
// ---------------------------------------------------------------------------
interface aes256_key_sched_if;

    logic [255:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         rk_valid;
    logic         rk_ready;

    modport slave (
        input  key_in, key_valid, rk_ready,
        output key_ready, rk, rk_idx, rk_last, rk_valid
    );

    modport master (
        output key_in, key_valid, rk_ready,
        input  key_ready, rk, rk_idx, rk_last, rk_valid
    );

endinterface

// File: rtl/aes_sub_word.sv
// ---------------------------------------------------------------------------
// aes_sub_word
// Combinational AES SubWord: applies the forward S-box to each byte.
//   word_i : 32-bit input word
//   word_o : 32-bit substituted word
// ---------------------------------------------------------------------------
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                     SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/aes256_key_sched.sv
// ---------------------------------------------------------------------------
// aes256_key_sched
// Sequential AES-256 key schedule. Latches a 256-bit key and streams round
// keys 0..NR one per rk_valid/rk_ready beat, using an 8-word sliding window
// instead of a full expansion.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : aes256_key_sched_if.slave (key load + round-key handshake)
// ---------------------------------------------------------------------------
module aes256_key_sched
    import aes_pkg::*;
#(
    parameter int NR = NR_256
) (
    input  logic              clk,
    input  logic              rst,
    aes256_key_sched_if.slave bus
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    ks_state_e    state_q, state_d;
    logic [255:0] window_q, window_d;
    logic [3:0]   idx_q, idx_d;

    logic [31:0]  word7;
    logic [31:0]  subIn;
    logic [31:0]  subOut;
    logic [31:0]  tWord;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] newWords;

    // Odd indices need SubWord only; even ones rotate first. One S-box
    // instance serves both by muxing its input on idx[0].
    assign word7 = window_q[31:0];
    assign subIn = idx_q[0] ? word7 : {word7[23:0], word7[31:24]};

    aes_sub_word u_sub_word (
        .word_i (subIn),
        .word_o (subOut)
    );

    // Next four schedule words from the window; for even n the round
    // constant index is n/2, which is simply idx[3:1].
    always_comb begin
        tWord    = idx_q[0] ? subOut : (subOut ^ {RCON[idx_q[3:1]], 24'h0});
        n0       = window_q[255:224] ^ tWord;
        n1       = window_q[223:192] ^ n0;
        n2       = window_q[191:160] ^ n1;
        n3       = window_q[159:128] ^ n2;
        newWords = {n0, n1, n2, n3};
    end

    // State, window and index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            window_q <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            idx_q    <= idx_d;
        end
    end

    // Keys 0 and 1 are the cipher key itself, so the window only starts
    // sliding once key 2 has been taken.
    always_comb begin
        state_d  = state_q;
        window_d = window_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    state_d  = EMIT;
                    window_d = bus.key_in;
                    idx_d    = '0;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d  = IDLE;
                        window_d = '0;
                        idx_d    = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q >= 4'd2) begin
                            window_d = {window_q[127:0], newWords};
                        end
                    end
                end
            end
        endcase
    end

    // Outputs depend only on registered state, never on the inputs.
    always_comb begin
        bus.key_ready = (state_q == IDLE);
        bus.rk_valid  = (state_q == EMIT);
        bus.rk_idx    = idx_q;
        bus.rk_last   = (state_q == EMIT) && (idx_q == LAST_IDX);
        bus.rk        = '0;
        if (state_q == EMIT) begin
            case (idx_q)
                4'd0:    bus.rk = window_q[255:128];
                4'd1:    bus.rk = window_q[127:0];
                default: bus.rk = newWords;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_key_sched.sv
// ---------------------------------------------------------------------------
// tb_aes256_key_sched
// Self-checking bench for aes256_key_sched. Expected round keys come from a
// full FIPS-197 word expansion with an S-box derived from GF(2^8) inversion.
// ---------------------------------------------------------------------------
module tb_aes256_key_sched;

    logic clk = 1'b0;
    logic rst;

    int compareCount = 0;
    int failCount    = 0;
    int cycleCount   = 0;

    logic [7:0]   sbox   [256];
    logic [127:0] expRk  [15];
    logic [127:0] seenRk [15];

    aes256_key_sched_if bus ();

    aes256_key_sched #(.NR(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock and cycle counter used for spacing checks.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Hard stop in case a wait never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [255:0] k, input logic kv, input logic rr);
        rst           = r;
        bus.key_in    = k;
        bus.key_valid = kv;
        bus.rk_ready  = rr;
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [15:0] d;
        d = {x, x} << k;
        return d[15:8];
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    // Plain FIPS-197 expansion of all 60 words, then grouped into round keys.
    task automatic expandKey(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] temp;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = w[i-1];
            if (i % 8 == 0)
                temp = subWord({temp[23:0], temp[31:24]}) ^ {8'(1 << (i/8 - 1)), 24'h0};
            else if (i % 8 == 4)
                temp = subWord(temp);
            w[i] = w[i-8] ^ temp;
        end
        for (int n = 0; n < 15; n++) expRk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_rk_valid"},  128'(bus.rk_valid),  128'(1'b0));
        checkOutput({tag, "_key_ready"}, 128'(bus.key_ready), 128'(1'b1));
        checkOutput({tag, "_rk"},        bus.rk,              128'h0);
        checkOutput({tag, "_rk_idx"},    128'(bus.rk_idx),    128'h0);
        checkOutput({tag, "_rk_last"},   128'(bus.rk_last),   128'(1'b0));
    endtask

    // Called at a negedge right after key_valid was raised. Follows one
    // sequence, stalling rk_ready randomly, and checks every cycle against
    // the expected index. Returns early (still in EMIT) when stopIdx is seen.
    task automatic runSequence(input logic [255:0] key, input int stallPct, input int injectIdx,
                               input logic [255:0] injectKey, input int stopIdx,
                               input bit holdValid, output int startCycle);
        int expIdx;
        int guard;
        bit done;
        bit rdy;
        expIdx     = 0;
        guard      = 0;
        done       = 1'b0;
        startCycle = 0;
        while (!done && guard < 400) begin
            @(negedge clk);
            if (guard == 0) startCycle = cycleCount;
            guard++;
            checkOutput("rk_valid",  128'(bus.rk_valid),  128'(1'b1));
            checkOutput("key_ready", 128'(bus.key_ready), 128'(1'b0));
            checkOutput("rk_idx",    128'(bus.rk_idx),    128'(expIdx));
            checkOutput($sformatf("rk[%0d]", expIdx), bus.rk, expRk[expIdx]);
            checkOutput("rk_last",   128'(bus.rk_last),   128'(expIdx == 14));
            seenRk[expIdx] = bus.rk;
            if (expIdx == stopIdx) return;
            rdy = ($urandom_range(99) >= 32'(stallPct));
            if (expIdx == injectIdx) applyStimulus(1'b0, injectKey, 1'b1, rdy);
            else                     applyStimulus(1'b0, key, holdValid, rdy);
            if (rdy) begin
                if (expIdx == 14) done = 1'b1;
                else              expIdx++;
            end
        end
        if (!done) begin
            checkOutput("seq_timeout", 128'(1'b0), 128'(1'b1));
            return;
        end
        @(negedge clk);
        checkIdle("post_seq");
        applyStimulus(1'b0, key, holdValid, 1'b0);
    endtask

    initial begin
        logic [255:0] key;
        logic [255:0] otherKey;
        int s1;
        int s2;

        buildSbox();

        // Reset with a competing key_valid: reset must win.
        applyStimulus(1'b1, {8{32'hdeadbeef}}, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkIdle("idle");

        // FIPS-197 example key, no stalls.
        key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        expandKey(key);
        applyStimulus(1'b0, key, 1'b1, 1'b1);
        runSequence(key, 0, -1, '0, -1, 1'b0, s1);
        checkOutput("fips_rk0",  seenRk[0],  128'h000102030405060708090a0b0c0d0e0f);
        checkOutput("fips_rk1",  seenRk[1],  128'h101112131415161718191a1b1c1d1e1f);
        checkOutput("fips_rk2",  seenRk[2],  128'ha573c29fa176c498a97fce93a572c09c);
        checkOutput("fips_rk3",  seenRk[3],  128'h1651a8cd0244beda1a5da4c10640bade);
        checkOutput("fips_rk14", seenRk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Second published key.
        key = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        expandKey(key);
        applyStimulus(1'b0, key, 1'b1, 1'b1);
        runSequence(key, 0, -1, '0, -1, 1'b0, s1);
        checkOutput("k2_w8",   128'(seenRk[2][127:96]), 128'h9ba35411);
        checkOutput("k2_rk14", seenRk[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Random keys with roughly half the cycles stalled.
        for (int r = 0; r < 4; r++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            expandKey(key);
            applyStimulus(1'b0, key, 1'b1, 1'b1);
            runSequence(key, 50, -1, '0, -1, 1'b0, s1);
        end

        // A different key offered at idx 5 must be ignored.
        key      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        otherKey = ~key;
        expandKey(key);
        applyStimulus(1'b0, key, 1'b1, 1'b1);
        runSequence(key, 30, 5, otherKey, -1, 1'b0, s1);

        // Reset in the middle of a sequence, then a clean restart.
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        expandKey(key);
        applyStimulus(1'b0, key, 1'b1, 1'b1);
        runSequence(key, 0, -1, '0, 7, 1'b0, s1);
        applyStimulus(1'b1, key, 1'b1, 1'b1);
        @(negedge clk);
        checkIdle("mid_reset");
        applyStimulus(1'b0, key, 1'b0, 1'b0);
        @(negedge clk);
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        expandKey(key);
        applyStimulus(1'b0, key, 1'b1, 1'b1);
        runSequence(key, 20, -1, '0, -1, 1'b0, s1);

        // key_valid held high: sequences restart every 16 cycles.
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        expandKey(key);
        applyStimulus(1'b0, key, 1'b1, 1'b1);
        runSequence(key, 0, -1, '0, -1, 1'b1, s1);
        runSequence(key, 0, -1, '0, -1, 1'b1, s2);
        checkOutput("b2b_spacing", 128'(s2 - s1), 128'd16);
        applyStimulus(1'b0, key, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checkIdle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
